// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
//   Shared definitions for the RV32I pipeline memory path:
//     - funct3 load/store size codes (F3_B/H/W/BU/HU)
//     - write-back source selectors (WB_SEL_MEM/ALU/PC4)
//     - mem_state_t, the MEM-stage handshake FSM state
//     - mem_size_t plus size_of(), which folds funct3 into an access width.
//       Every funct3 code outside B/H/BU/HU is treated as a full word.
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] WB_SEL_MEM = 2'd0;
    localparam logic [1:0] WB_SEL_ALU = 2'd1;
    localparam logic [1:0] WB_SEL_PC4 = 2'd2;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } mem_size_t;

    function automatic mem_size_t size_of(input logic [2:0] funct3);
        mem_size_t sz;
        case (funct3)
            F3_B, F3_BU: sz = SZ_B;
            F3_H, F3_HU: sz = SZ_H;
            default:     sz = SZ_W;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/load_store_align.sv
// ---------------------------------------------------------------------------
// load_store_align
//   Purely combinational byte-lane logic for the MEM stage.
//   Ports:
//     addr_lo    in  2   low address bits (byte offset within the word)
//     funct3     in  3   access size / sign code
//     rs2        in  32  store data, unshifted
//     rdata      in  32  raw word returned by data memory
//     be         out 4   byte enables for the store lanes
//     wdata      out 32  store data shifted into its lanes
//     load_data  out 32  extracted and sign/zero-extended load result
//     misaligned out 1   halfword at odd address or word not on a 4-byte boundary
// ---------------------------------------------------------------------------
module load_store_align
    import riscv_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs2,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    mem_size_t   size;
    logic [4:0]  lane_shift;
    logic [31:0] shifted;

    always_comb begin
        size       = size_of(funct3);
        lane_shift = {addr_lo, 3'b000};
        shifted    = rdata >> lane_shift;
        wdata      = rs2 << lane_shift;
        be         = 4'b1111;
        misaligned = 1'b0;
        load_data  = rdata;
        case (size)
            SZ_B: begin
                be = 4'b0001 << addr_lo;
                // funct3[2] distinguishes the unsigned variant (BU)
                load_data = funct3[2] ? {24'b0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
            end
            SZ_H: begin
                be         = 4'b0011 << addr_lo;
                misaligned = addr_lo[0];
                load_data  = funct3[2] ? {16'b0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
            end
            default: begin
                misaligned = |addr_lo;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
//   MEM stage of the five-stage RV32I pipeline. Issues data-memory requests,
//   holds the pipeline while an access is outstanding, and registers the
//   MEM/WB latch consumed by write_back.
//
//   Handshake: dmem_req is held high from the first cycle of an access until
//   the cycle dmem_ready is seen high; that cycle completes the access (and
//   for loads dmem_rdata is captured). dmem_ready is ignored whenever
//   dmem_req is low. stall = dmem_req & ~dmem_ready: upstream keeps ex_*
//   stable while stall is high and advances on the completing cycle.
//
//   Ports:
//     clock, reset                 clock, synchronous active-high reset
//     ex_*                         EX/MEM slot (valid, pc, alu, rs2, funct3,
//                                  mem_rd, mem_wr, wb_sel, rd, reg_wen)
//     dmem_req/we/addr/be/wdata    data-memory request
//     dmem_ready, dmem_rdata       data-memory response
//     stall                        hold upstream
//     misalign                     registered, flags the wb_* slot it rides with
//     wb_*                         MEM/WB latch
//     fsm_state                    current handshake state (observability)
// ---------------------------------------------------------------------------
module mem_stage
    import riscv_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_alu,
    input  logic [31:0] ex_rs2,
    input  logic [2:0]  ex_funct3,
    input  logic        ex_mem_rd,
    input  logic        ex_mem_wr,
    input  logic [1:0]  ex_wb_sel,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_wen,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        misalign,
    output logic        wb_valid,
    output logic [31:0] wb_pc,
    output logic [31:0] wb_alu,
    output logic [31:0] wb_data_r,
    output logic [1:0]  wb_sel,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_wen,
    output mem_state_t  fsm_state
);

    mem_state_t  state, state_next;
    logic        misaligned;
    logic [31:0] load_data;
    logic        is_mem;
    logic        mem_op;
    logic        misalign_now;
    logic        load_ok;

    load_store_align u_align (
        .addr_lo    (ex_alu[1:0]),
        .funct3     (ex_funct3),
        .rs2        (ex_rs2),
        .rdata      (dmem_rdata),
        .be         (dmem_be),
        .wdata      (dmem_wdata),
        .load_data  (load_data),
        .misaligned (misaligned)
    );

    assign is_mem       = ex_valid & (ex_mem_rd | ex_mem_wr);
    assign mem_op       = is_mem & ~misaligned;
    assign misalign_now = is_mem & misaligned;
    // A slot with both rd and wr set is a store, so it never returns load data.
    assign load_ok      = mem_op & ex_mem_rd & ~ex_mem_wr;

    assign dmem_addr = {ex_alu[31:2], 2'b00};
    assign dmem_we   = dmem_req & ex_mem_wr;
    assign fsm_state = state;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Reset gates the request immediately so an access abandoned in WAIT
    // drops dmem_req in the same cycle; the late response is then ignored.
    always_comb begin
        state_next = state;
        dmem_req   = 1'b0;
        stall      = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (mem_op) begin
                        dmem_req = 1'b1;
                        if (!dmem_ready) begin
                            stall      = 1'b1;
                            state_next = WAIT;
                        end
                    end
                end
                WAIT: begin
                    dmem_req = 1'b1;
                    if (dmem_ready) begin
                        state_next = IDLE;
                    end else begin
                        stall = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // MEM/WB latch: loads a zero bubble while stalled, otherwise the slot.
    always_ff @(posedge clock) begin
        if (reset || stall) begin
            wb_valid   <= 1'b0;
            wb_pc      <= 32'b0;
            wb_alu     <= 32'b0;
            wb_data_r  <= 32'b0;
            wb_sel     <= 2'b0;
            wb_rd      <= 5'b0;
            wb_reg_wen <= 1'b0;
            misalign   <= 1'b0;
        end else begin
            wb_valid   <= ex_valid;
            wb_pc      <= ex_pc;
            wb_alu     <= ex_alu;
            wb_data_r  <= load_ok ? load_data : 32'b0;
            wb_sel     <= ex_wb_sel;
            wb_rd      <= ex_rd;
            wb_reg_wen <= ex_valid & ex_reg_wen & ~ex_mem_wr & ~misalign_now;
            misalign   <= misalign_now;
        end
    end

endmodule
